// File: rtl/div_unit.sv
// Multicycle signed restoring divider for the MIPS DIV instruction.
// Remainder goes to hi, quotient to lo; one quotient bit is resolved per cycle.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign_q, r_sign_r;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done, r_divzero;

  logic             w_start, w_zero, w_last;
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_busy_nxt, w_done_nxt, w_dz_nxt;

  assign w_start = DivCtrl && (r_state == S_IDLE) && (b != '0);
  assign w_zero  = DivCtrl && (r_state == S_IDLE) && (b == '0);
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // The remainder carries one extra bit so the trial subtract's sign is its MSB.
  assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_CALC;
      S_CALC: if (w_last)  w_next = S_FIX;
      S_FIX:               w_next = S_DONE;
      S_DONE:              w_next = S_IDLE;
      default:             w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_next != S_IDLE);
    w_done_nxt = (r_state == S_FIX);
    w_dz_nxt   = w_zero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_divzero <= w_dz_nxt;
      case (r_state)
        S_IDLE: if (w_start) begin
          // Magnitudes are unsigned, so the most-negative dividend maps to 2^(WIDTH-1) cleanly.
          r_dvd    <= a[WIDTH-1] ? (~a + 1'b1) : a;
          r_dvs    <= b[WIDTH-1] ? (~b + 1'b1) : b;
          r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
          r_sign_r <= a[WIDTH-1];
          r_rem    <= '0;
          r_cnt    <= '0;
        end
        S_CALC: begin
          if (!w_trial[WIDTH]) r_rem <= w_trial;
          else                 r_rem <= w_shift;
          r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_lo <= r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
          r_hi <= r_sign_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign hi      = r_hi;
  assign lo      = r_lo;
  assign busy    = r_busy;
  assign done    = r_done;
  assign divZero = r_divzero;

endmodule
